// File: rtl/stream_mux_rr_if.sv
// Handshake bundle between NUM_CH producers, the round-robin mux and its consumer.
// Optional in_last/out_last appear when STREAM_MUX_LAST_EN is defined.
// Flow control is plain valid/ready on every side.
interface stream_mux_rr_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8
);
    localparam int CH_W = $clog2(NUM_CH);

    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH-1:0]        in_ready;
    logic [DATA_W-1:0]        out_data;
    logic [CH_W-1:0]          out_ch;
    logic                     out_valid;
    logic                     out_ready;
`ifdef STREAM_MUX_LAST_EN
    logic [NUM_CH-1:0]        in_last;
    logic                     out_last;
`endif

    // Producers and the consumer side, as seen from outside the mux.
    modport master (
`ifdef STREAM_MUX_LAST_EN
        output in_last,
        input  out_last,
`endif
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_ch,
        input  out_valid,
        output out_ready
    );

    modport slave (
`ifdef STREAM_MUX_LAST_EN
        input  in_last,
        output out_last,
`endif
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_ch,
        output out_valid,
        input  out_ready
    );
endinterface

// File: rtl/stream_mux_rr.sv
// N-to-1 round-robin stream mux with a registered output; STREAM_MUX_LAST_EN adds packet lock.
// Latency: 1 cycle from input handshake to out_valid, 1 beat/cycle sustained.
// Backpressure: out_valid && !out_ready stalls the register and holds every in_ready low.
module stream_mux_rr #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    stream_mux_rr_if.slave bus
);
    localparam int CH_W = $clog2(NUM_CH);

    logic [CH_W-1:0]   ptr;
    logic [CH_W-1:0]   ptr_inc;
    logic [CH_W-1:0]   gidx;
    logic [CH_W:0]     cand;
    logic [NUM_CH-1:0] elig;
    logic [DATA_W-1:0] sel_data;
    logic              grant;
    logic              load_en;
    logic              take;

`ifdef STREAM_MUX_LAST_EN
    typedef enum logic {
        ST_FREE,
        ST_LOCK
    } lock_state_t;

    lock_state_t     state;
    lock_state_t     state_nxt;
    logic [CH_W-1:0] lock_ch;
    logic [CH_W-1:0] lock_ch_nxt;
    logic            sel_last;

    // While a packet is open only its owner may compete.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            elig[i] = bus.in_valid[i] && ((state == ST_FREE) || (lock_ch == CH_W'(i)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_FREE;
            lock_ch <= '0;
        end else begin
            state   <= state_nxt;
            lock_ch <= lock_ch_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        lock_ch_nxt = lock_ch;
        if (take) begin
            if (sel_last) begin
                state_nxt = ST_FREE;
            end else begin
                state_nxt   = ST_LOCK;
                lock_ch_nxt = gidx;
            end
        end
    end

    assign sel_last = bus.in_last[gidx];
`else
    assign elig = bus.in_valid;
`endif

    assign load_en = !bus.out_valid || bus.out_ready;
    // Nothing is accepted while reset is held, even though the register reads empty.
    assign take    = rst_n && load_en && grant;

    // Wrapping search starting at ptr; candidate index folded by subtraction so
    // non-power-of-two channel counts never rely on overflow.
    always_comb begin
        grant = 1'b0;
        gidx  = '0;
        cand  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = {1'b0, ptr} + (CH_W+1)'(k);
            if (cand >= (CH_W+1)'(NUM_CH)) begin
                cand = cand - (CH_W+1)'(NUM_CH);
            end
            if (!grant && elig[cand[CH_W-1:0]]) begin
                grant = 1'b1;
                gidx  = cand[CH_W-1:0];
            end
        end
    end

    always_comb begin
        bus.in_ready = '0;
        sel_data     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            bus.in_ready[i] = take && (gidx == CH_W'(i));
            if (gidx == CH_W'(i)) begin
                sel_data = bus.in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign ptr_inc = (gidx == CH_W'(NUM_CH - 1)) ? '0 : gidx + CH_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_ch    <= '0;
            ptr           <= '0;
`ifdef STREAM_MUX_LAST_EN
            bus.out_last  <= 1'b0;
`endif
        end else if (load_en) begin
            if (grant) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= sel_data;
                bus.out_ch    <= gidx;
`ifdef STREAM_MUX_LAST_EN
                bus.out_last  <= sel_last;
                if (sel_last) begin
                    ptr <= ptr_inc;
                end
`else
                ptr           <= ptr_inc;
`endif
            end else begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule
